// File: rtl/des_pkg.sv
// DES round-function constants: S-box contents, P permutation and datapath widths.
// Bit numbering follows the DES standard: DES bit n of a W-bit word sits at index W-n.
package des_pkg;

    localparam int DES_EW = 48;
    localparam int DES_FW = 32;

    // SBOX[box][row*16 + col]
    localparam logic [3:0] SBOX [8][64] = '{
        '{4'd14, 4'd4,  4'd13, 4'd1,  4'd2,  4'd15, 4'd11, 4'd8,  4'd3,  4'd10, 4'd6,  4'd12, 4'd5,  4'd9,  4'd0,  4'd7,
          4'd0,  4'd15, 4'd7,  4'd4,  4'd14, 4'd2,  4'd13, 4'd1,  4'd10, 4'd6,  4'd12, 4'd11, 4'd9,  4'd5,  4'd3,  4'd8,
          4'd4,  4'd1,  4'd14, 4'd8,  4'd13, 4'd6,  4'd2,  4'd11, 4'd15, 4'd12, 4'd9,  4'd7,  4'd3,  4'd10, 4'd5,  4'd0,
          4'd15, 4'd12, 4'd8,  4'd2,  4'd4,  4'd9,  4'd1,  4'd7,  4'd5,  4'd11, 4'd3,  4'd14, 4'd10, 4'd0,  4'd6,  4'd13},
        '{4'd15, 4'd1,  4'd8,  4'd14, 4'd6,  4'd11, 4'd3,  4'd4,  4'd9,  4'd7,  4'd2,  4'd13, 4'd12, 4'd0,  4'd5,  4'd10,
          4'd3,  4'd13, 4'd4,  4'd7,  4'd15, 4'd2,  4'd8,  4'd14, 4'd12, 4'd0,  4'd1,  4'd10, 4'd6,  4'd9,  4'd11, 4'd5,
          4'd0,  4'd14, 4'd7,  4'd11, 4'd10, 4'd4,  4'd13, 4'd1,  4'd5,  4'd8,  4'd12, 4'd6,  4'd9,  4'd3,  4'd2,  4'd15,
          4'd13, 4'd8,  4'd10, 4'd1,  4'd3,  4'd15, 4'd4,  4'd2,  4'd11, 4'd6,  4'd7,  4'd12, 4'd0,  4'd5,  4'd14, 4'd9},
        '{4'd10, 4'd0,  4'd9,  4'd14, 4'd6,  4'd3,  4'd15, 4'd5,  4'd1,  4'd13, 4'd12, 4'd7,  4'd11, 4'd4,  4'd2,  4'd8,
          4'd13, 4'd7,  4'd0,  4'd9,  4'd3,  4'd4,  4'd6,  4'd10, 4'd2,  4'd8,  4'd5,  4'd14, 4'd12, 4'd11, 4'd15, 4'd1,
          4'd13, 4'd6,  4'd4,  4'd9,  4'd8,  4'd15, 4'd3,  4'd0,  4'd11, 4'd1,  4'd2,  4'd12, 4'd5,  4'd10, 4'd14, 4'd7,
          4'd1,  4'd10, 4'd13, 4'd0,  4'd6,  4'd9,  4'd8,  4'd7,  4'd4,  4'd15, 4'd14, 4'd3,  4'd11, 4'd5,  4'd2,  4'd12},
        '{4'd7,  4'd13, 4'd14, 4'd3,  4'd0,  4'd6,  4'd9,  4'd10, 4'd1,  4'd2,  4'd8,  4'd5,  4'd11, 4'd12, 4'd4,  4'd15,
          4'd13, 4'd8,  4'd11, 4'd5,  4'd6,  4'd15, 4'd0,  4'd3,  4'd4,  4'd7,  4'd2,  4'd12, 4'd1,  4'd10, 4'd14, 4'd9,
          4'd10, 4'd6,  4'd9,  4'd0,  4'd12, 4'd11, 4'd7,  4'd13, 4'd15, 4'd1,  4'd3,  4'd14, 4'd5,  4'd2,  4'd8,  4'd4,
          4'd3,  4'd15, 4'd0,  4'd6,  4'd10, 4'd1,  4'd13, 4'd8,  4'd9,  4'd4,  4'd5,  4'd11, 4'd12, 4'd7,  4'd2,  4'd14},
        '{4'd2,  4'd12, 4'd4,  4'd1,  4'd7,  4'd10, 4'd11, 4'd6,  4'd8,  4'd5,  4'd3,  4'd15, 4'd13, 4'd0,  4'd14, 4'd9,
          4'd14, 4'd11, 4'd2,  4'd12, 4'd4,  4'd7,  4'd13, 4'd1,  4'd5,  4'd0,  4'd15, 4'd10, 4'd3,  4'd9,  4'd8,  4'd6,
          4'd4,  4'd2,  4'd1,  4'd11, 4'd10, 4'd13, 4'd7,  4'd8,  4'd15, 4'd9,  4'd12, 4'd5,  4'd6,  4'd3,  4'd0,  4'd14,
          4'd11, 4'd8,  4'd12, 4'd7,  4'd1,  4'd14, 4'd2,  4'd13, 4'd6,  4'd15, 4'd0,  4'd9,  4'd10, 4'd4,  4'd5,  4'd3},
        '{4'd12, 4'd1,  4'd10, 4'd15, 4'd9,  4'd2,  4'd6,  4'd8,  4'd0,  4'd13, 4'd3,  4'd4,  4'd14, 4'd7,  4'd5,  4'd11,
          4'd10, 4'd15, 4'd4,  4'd2,  4'd7,  4'd12, 4'd9,  4'd5,  4'd6,  4'd1,  4'd13, 4'd14, 4'd0,  4'd11, 4'd3,  4'd8,
          4'd9,  4'd14, 4'd15, 4'd5,  4'd2,  4'd8,  4'd12, 4'd3,  4'd7,  4'd0,  4'd4,  4'd10, 4'd1,  4'd13, 4'd11, 4'd6,
          4'd4,  4'd3,  4'd2,  4'd12, 4'd9,  4'd5,  4'd15, 4'd10, 4'd11, 4'd14, 4'd1,  4'd7,  4'd6,  4'd0,  4'd8,  4'd13},
        '{4'd4,  4'd11, 4'd2,  4'd14, 4'd15, 4'd0,  4'd8,  4'd13, 4'd3,  4'd12, 4'd9,  4'd7,  4'd5,  4'd10, 4'd6,  4'd1,
          4'd13, 4'd0,  4'd11, 4'd7,  4'd4,  4'd9,  4'd1,  4'd10, 4'd14, 4'd3,  4'd5,  4'd12, 4'd2,  4'd15, 4'd8,  4'd6,
          4'd1,  4'd4,  4'd11, 4'd13, 4'd12, 4'd3,  4'd7,  4'd14, 4'd10, 4'd15, 4'd6,  4'd8,  4'd0,  4'd5,  4'd9,  4'd2,
          4'd6,  4'd11, 4'd13, 4'd8,  4'd1,  4'd4,  4'd10, 4'd7,  4'd9,  4'd5,  4'd0,  4'd15, 4'd14, 4'd2,  4'd3,  4'd12},
        '{4'd13, 4'd2,  4'd8,  4'd4,  4'd6,  4'd15, 4'd11, 4'd1,  4'd10, 4'd9,  4'd3,  4'd14, 4'd5,  4'd0,  4'd12, 4'd7,
          4'd1,  4'd15, 4'd13, 4'd8,  4'd10, 4'd3,  4'd7,  4'd4,  4'd12, 4'd5,  4'd6,  4'd11, 4'd0,  4'd14, 4'd9,  4'd2,
          4'd7,  4'd11, 4'd4,  4'd1,  4'd9,  4'd12, 4'd14, 4'd2,  4'd0,  4'd6,  4'd10, 4'd13, 4'd15, 4'd3,  4'd5,  4'd8,
          4'd2,  4'd1,  4'd14, 4'd7,  4'd4,  4'd10, 4'd8,  4'd13, 4'd15, 4'd12, 4'd9,  4'd0,  4'd3,  4'd5,  4'd6,  4'd11}
    };

    // Output DES bit j takes S-output DES bit P_TABLE[j-1]
    localparam int P_TABLE [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25
    };

endpackage

// File: rtl/des_sbox_lookup.sv
// Eight parallel DES S-box reads: 48-bit keyed word in, 32-bit S-output out.
// Latency: combinational. Backpressure: none, pure datapath.
// Row is the outer bit pair of each 6-bit group, column the inner four bits.
module des_sbox_lookup
    import des_pkg::*;
(
    input  logic [DES_EW-1:0] x_i,
    output logic [DES_FW-1:0] s_o
);

    for (genvar b = 0; b < 8; b++) begin : g_box
        logic [5:0] chunk;
        assign chunk = x_i[DES_EW-1-6*b -: 6];
        assign s_o[DES_FW-1-4*b -: 4] = SBOX[b][{chunk[5], chunk[0], chunk[4:1]}];
    end

endmodule

// File: rtl/des_sbox_perm_stage.sv
// DES round function f(R,K): key XOR, S-boxes, P permutation; DES_FSTAT_EN adds a transfer counter.
// Latency: 2 cycles with PIPE_XOR=1, 1 cycle with PIPE_XOR=0; one result per cycle sustained.
// Backpressure: valid/ready, in_ready is combinational from out_ready (no skid buffer).
module des_sbox_perm_stage
    import des_pkg::*;
#(
    parameter int PIPE_XOR = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DES_EW-1:0] e_in,
    input  logic [DES_EW-1:0] k_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DES_FW-1:0] f_out,
    output logic [15:0]       xfer_cnt
);

    function automatic logic [DES_FW-1:0] p_perm(input logic [DES_FW-1:0] s);
        logic [DES_FW-1:0] p;
        p = '0;
        for (int j = 1; j <= DES_FW; j++) begin
            p[DES_FW-j] = s[DES_FW-P_TABLE[j-1]];
        end
        return p;
    endfunction

    logic              s2_adv;
    logic              s2_load;
    logic [DES_EW-1:0] s2_x;
    logic [DES_FW-1:0] s_out;
    logic              s2_v_q, s2_v_d;
    logic [DES_FW-1:0] s2_f_q, s2_f_d;

    assign s2_adv = !s2_v_q || out_ready;

    if (PIPE_XOR != 0) begin : g_pipe
        logic              s1_v_q, s1_v_d;
        logic [DES_EW-1:0] s1_x_q, s1_x_d;

        assign in_ready = !s1_v_q || s2_adv;

        always_comb begin
            s1_v_d = s1_v_q;
            s1_x_d = s1_x_q;
            if (in_ready) begin
                s1_v_d = in_valid;
                if (in_valid) begin
                    s1_x_d = e_in ^ k_in;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_v_q <= 1'b0;
                s1_x_q <= '0;
            end else begin
                s1_v_q <= s1_v_d;
                s1_x_q <= s1_x_d;
            end
        end

        assign s2_x    = s1_x_q;
        assign s2_load = s1_v_q;
    end else begin : g_fold
        assign in_ready = s2_adv;
        assign s2_x     = e_in ^ k_in;
        assign s2_load  = in_valid;
    end

    des_sbox_lookup u_sbox (
        .x_i (s2_x),
        .s_o (s_out)
    );

    // f_out keeps its last value when the pipeline drains
    always_comb begin
        s2_v_d = s2_v_q;
        s2_f_d = s2_f_q;
        if (s2_adv) begin
            s2_v_d = s2_load;
            if (s2_load) begin
                s2_f_d = p_perm(s_out);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v_q <= 1'b0;
            s2_f_q <= '0;
        end else begin
            s2_v_q <= s2_v_d;
            s2_f_q <= s2_f_d;
        end
    end

    assign out_valid = s2_v_q;
    assign f_out     = s2_f_q;

`ifdef DES_FSTAT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && out_ready) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign xfer_cnt = cnt_q;
`else
    assign xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_des_sbox_perm_stage.sv
// Scoreboard bench for des_sbox_perm_stage: expected f(R,K) queued on every accept,
// popped and compared by an independent monitor on every output transfer.
module tb_des_sbox_perm_stage;

    localparam int PIPE_XOR = 1;
    localparam int LAT      = PIPE_XOR + 1;

    // S-box rows as 16 hex nibbles each, four rows per box (row 0 in the top bits)
    localparam logic [255:0] SB_HEX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };
    localparam int P_BENCH [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] e_in;
    logic [47:0] k_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] f_out;
    logic [15:0] xfer_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int acc_cyc = 0;
    int last_pop_cyc = 0;
    int cnt_model = 0;
    logic [31:0] exp_q[$];
    logic        stalled = 1'b0;
    logic [31:0] held_f = '0;

    des_sbox_perm_stage #(.PIPE_XOR(PIPE_XOR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .e_in      (e_in),
        .k_in      (k_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f_out     (f_out),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference f(R,K) worked entirely in DES bit numbering (bit 1 = leftmost)
    function automatic logic [31:0] ref_f(input logic [47:0] e, input logic [47:0] k);
        logic [47:0]  x;
        logic [255:0] tbl;
        logic [3:0]   v;
        int           xb [1:48];
        int           sb [1:32];
        int           row, col, base;
        logic [31:0]  f;
        x = e ^ k;
        f = '0;
        for (int n = 1; n <= 48; n++) xb[n] = int'(x[48-n]);
        for (int b = 1; b <= 8; b++) begin
            base = 6 * (b - 1);
            row  = 2 * xb[base+1] + xb[base+6];
            col  = 8 * xb[base+2] + 4 * xb[base+3] + 2 * xb[base+4] + xb[base+5];
            tbl  = SB_HEX[b-1];
            v    = tbl[255 - 4 * (row * 16 + col) -: 4];
            for (int m = 0; m < 4; m++) sb[4*(b-1)+1+m] = int'(v[3-m]);
        end
        for (int j = 1; j <= 32; j++) f[32-j] = sb[P_BENCH[j-1]][0];
        return f;
    endfunction

    function automatic logic [47:0] rnd48();
        logic [31:0] a, b;
        a = $urandom;
        b = $urandom;
        return {a[15:0], b};
    endfunction

    // Input side of the scoreboard
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            exp_q.push_back(ref_f(e_in, k_in));
            acc_cnt++;
            acc_cyc = cyc;
        end
    end

    // Output monitor: ordered compare plus hold-while-stalled
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid_held", 64'(out_valid), 64'd1);
                check("stall_f_held", 64'(f_out), 64'(held_f));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 64'(f_out), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    check("f_out", 64'(f_out), 64'(exp_q.pop_front()));
                end
                cnt_model++;
                last_pop_cyc = cyc;
            end
            stalled = out_valid && !out_ready;
            held_f  = f_out;
        end
    end

    // Entered and left at posedge+1; holds data until accepted
    task automatic send(input logic [47:0] e, input logic [47:0] k);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        e_in     = e;
        k_in     = k;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            guard++;
            if (guard > 100) begin
                check("send_timeout", 64'(guard), 64'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string name, input logic [47:0] e, input logic [47:0] k,
                            input logic [31:0] fexp);
        int g;
        send(e, k);
        @(negedge clk);
        g = 0;
        while (!out_valid && g < 10) begin
            @(negedge clk);
            g++;
        end
        check({name, "_latency"}, 64'(cyc - acc_cyc), 64'(LAT));
        check({name, "_value"}, 64'(f_out), 64'(fexp));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a0, first_cyc;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        e_in      = '0;
        k_in      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_f_out", 64'(f_out), 64'd0);
        check("rst_xfer_cnt", 64'(xfer_cnt), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        directed("known_vec", 48'h7A15557A1555, 48'h1B02EFFC7072, 32'h234AA9BB);
        directed("zero_vec", 48'h0, 48'h0, 32'hD8D8DBBC);
        wait_drain("drain_directed");

        // Back-to-back streaming: results must come out on consecutive cycles
        send(rnd48(), rnd48());
        first_cyc = acc_cyc;
        for (int i = 1; i < 16; i++) send(rnd48(), rnd48());
        wait_drain("drain_stream");
        check("stream_no_bubble", 64'(last_pop_cyc - first_cyc), 64'(15 + LAT));

        // Full stall: pipeline fills, then in_ready drops
        out_ready = 1'b0;
        a0        = acc_cnt;
        in_valid  = 1'b1;
        e_in      = rnd48();
        k_in      = rnd48();
        for (int i = 0; i < 5; i++) begin
            logic acc;
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                e_in = rnd48();
                k_in = rnd48();
            end
        end
        check("stall_accepts", 64'(acc_cnt - a0), 64'(LAT));
        check("stall_in_ready", 64'(in_ready), 64'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain("drain_stall");

        // Random backpressure during a stream
        fork
            begin
                for (int i = 0; i < 20; i++) send(rnd48(), rnd48());
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        wait_drain("drain_random_bp");

        // Reset with both stages occupied
        out_ready = 1'b0;
        send(rnd48(), rnd48());
        send(rnd48(), rnd48());
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        cnt_model = 0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_f_out", 64'(f_out), 64'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(48'h0123456789AB, 48'hFEDCBA987654);
        send(rnd48(), rnd48());
        wait_drain("drain_post_reset");

`ifdef DES_FSTAT_EN
        rst_n = 1'b0;
        exp_q.delete();
        cnt_model = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 65537; i++) send(48'(i), 48'h5A5A5A5A5A5A);
        wait_drain("drain_preload");
        check("xfer_cnt_wrap", 64'(xfer_cnt), 64'd1);
        check("xfer_cnt_model", 64'(xfer_cnt), 64'(cnt_model % 65536));
`else
        check("xfer_cnt_tied", 64'(xfer_cnt), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/des_sbox_perm_stage.md
Name: des_sbox_perm_stage

Overview:
- Downstream neighbour of the DES expansion stage; consumes its 48-bit expanded right half.
- Datapath: XORs the 48-bit expanded word with the round subkey, evaluates the eight S-boxes, applies the P permutation, and emits the 32-bit round-function result f(R,K).
- Two-stage pipeline with valid/ready handshakes on both sides, so the round controller can stall without losing data.

Parameters:
- PIPE_XOR, 1, 1 = register stage after XOR (2-cycle latency); 0 = XOR folded into stage 2 (1-cycle latency).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  e_in/k_in valid
- in_ready  output  1  stage can accept this cycle
- e_in  input  48  expanded right half; DES bit n at index 48-n
- k_in  input  48  round subkey, same bit order
- out_valid  output  1  f_out valid
- out_ready  input  1  consumer accepts
- f_out  output  32  f(R,K); DES bit n at index 32-n
- xfer_cnt  output  16  completed output transfers (only with DES_FSTAT_EN)

Behaviour:
- Reset: asynchronous, active-low, one clock domain.
  - All valid flags clear; out_valid=0, f_out=0, xfer_cnt=0.
  - in_ready=1 from the first cycle after rst_n deasserts.
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Stage 1 (PIPE_XOR=1): s1_x <= e_in ^ k_in; s1_v set on input transfer.
- Stage 2:
  - s2_f <= P(S(s1_x)); s2_v set when stage 1 advances.
  - f_out = s2_f; out_valid = s2_v.
- S-box addressing:
  - Box i (1..8) takes x[53-6i : 48-6i].
  - Row = {first bit, last bit}; column = middle four bits.
  - 4-bit result placed at S[35-4i : 32-4i].
- P: standard DES P table, output bit j = S bit P[j]; pure wiring.
- Stall rules:
  - s2 advances when !s2_v || out_ready.
  - s1 advances when !s1_v || s2 advances.
  - in_ready = s1 advances (combinational from out_ready; no skid buffer).
- Throughput and latency:
  - One result per cycle sustained while out_ready=1.
  - Latency: in transfer at cycle t -> out_valid at t+2 (PIPE_XOR=1) or t+1 (PIPE_XOR=0).
- Stall/bubble:
  - out_ready low with both stages full: in_ready=0, registers hold, f_out stable.
  - Output never changes while out_valid && !out_ready.
- Simultaneous output transfer and input transfer in the same cycle: both occur; no bubble inserted.
- Empty pipeline: f_out holds its last value; out_valid=0.
- Reset mid-operation: in-flight data is discarded with no partial output; f_out returns to 0.

Optional Feature:
- Macro DES_FSTAT_EN.
- Defined: xfer_cnt increments by 1 on each output transfer, wraps 0xFFFF -> 0x0000, and is cleared by reset.
- Undefined: the port remains present, tied to 0, with no counter flops.

Decomposition:
- Package des_pkg holds:
  - the SBOX constant array [8][64] of 4-bit entries;
  - the P_TABLE constant [32];
  - widths DES_EW=48, DES_FW=32.
- One sub-module, des_sbox_lookup: combinational, 48-bit in -> 32-bit S-output, eight table reads.
- P permutation and pipeline control stay in the top level.

Test Plan:
- Known round-1 vector: e_in=0x7A15557A1555, k_in=0x1B02EFFC7072 -> f_out=0x234AA9BB; out_valid 2 cycles after the accept.
- Zero input: e_in=0, k_in=0 -> f_out=0xD8D8DBBC (S-output 0xEFA72C4D).
- Streaming:
  - 16 back-to-back random vectors with out_ready=1 -> one result per cycle, in order, matching the reference model; zero bubbles.
- Backpressure:
  - out_ready=0 for 5 cycles with in_valid=1 -> in_ready drops after 2 accepts.
  - f_out is held constant throughout the stall.
  - Releasing out_ready drains in order with no loss or duplication.
- Reset mid-stream: assert rst_n low with both stages valid -> out_valid=0 and f_out=0 immediately (asynchronous); first post-reset vector returns a correct result.
- DES_FSTAT_EN: preload via 65537 transfers -> xfer_cnt=1 (wrap verified); without the macro, xfer_cnt stays 0.
